dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single data memory port between the pipeline MEM stage (requester 0) and the debug/program-loader port (requester 1). Requester 0 has fixed priority; a starvation counter forces a grant to requester 1 after a bounded wait. Granted accesses drive the memory's write-enable, funct3, address and write-data inputs combinationally. Read data is registered and returned one cycle later. An optional checker rejects misaligned accesses before they reach memory.

---
 rtl/dmem_arbiter_if.sv | 41 ++++
 rtl/dmem_arbiter.sv | 96 +++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dmem_arbiter.
// Handshake: a requester raises req with fields stable; gnt in the same cycle
// issues the access; rvalid pulses for one cycle with rdata/rerr in the next.
// There is no backpressure on responses.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_req, m1_req;
  logic                  m0_we, m1_we;
  logic [2:0]            m0_funct3, m1_funct3;
  logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
  logic [DATA_WIDTH-1:0] m0_wdata, m1_wdata;
  logic                  m0_gnt, m1_gnt;
  logic                  m0_rvalid, m1_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;
  logic                  m0_rerr, m1_rerr;
  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  m0_req, m0_we, m0_funct3, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_funct3, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_rerr,
    output m1_gnt, m1_rvalid, m1_rdata, m1_rerr,
    output mem_wr_en, mem_funct3, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output m0_req, m0_we, m0_funct3, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_funct3, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_rerr,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_rerr,
    input  mem_wr_en, mem_funct3, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority data-memory arbiter (MEM stage = 0, debug loader = 1) with a
// starvation counter. Define DMEM_ARB_MISALIGN_CHK_EN to block misaligned accesses.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus,
  output logic [3:0]      starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic gnt0, gnt1;
  logic mis0, mis1;
  logic win_mis;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
  // Only the defined half/word codes are checked; reserved funct3 passes.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return a != 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  assign mis0 = misaligned(bus.m0_funct3, bus.m0_addr[1:0]);
  assign mis1 = misaligned(bus.m1_funct3, bus.m1_addr[1:0]);
`else
  assign mis0 = 1'b0;
  assign mis1 = 1'b0;
`endif

  always_comb begin
    gnt1 = bus.m1_req && ((starve_cnt == LIMIT) || !bus.m0_req);
    gnt0 = bus.m0_req && !gnt1;
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;

  always_comb begin
    bus.mem_wr_en   = 1'b0;
    bus.mem_funct3  = 3'b000;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    win_mis         = 1'b0;
    if (gnt1) begin
      bus.mem_wr_en   = bus.m1_we;
      bus.mem_funct3  = bus.m1_funct3;
      bus.mem_addr    = bus.m1_addr;
      bus.mem_wr_data = bus.m1_wdata;
      win_mis         = mis1;
    end else if (gnt0) begin
      bus.mem_wr_en   = bus.m0_we;
      bus.mem_funct3  = bus.m0_funct3;
      bus.mem_addr    = bus.m0_addr;
      bus.mem_wr_data = bus.m0_wdata;
      win_mis         = mis0;
    end
    // A grant during reset stays visible but must never commit a store.
    if (win_mis || reset) bus.mem_wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!bus.m1_req || gnt1) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m0_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m0_rerr   <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m1_rdata  <= '0;
      bus.m1_rerr   <= 1'b0;
    end else begin
      bus.m0_rvalid <= gnt0;
      bus.m0_rdata  <= (gnt0 && !bus.m0_we && !mis0) ? bus.mem_rd_data : '0;
      bus.m0_rerr   <= gnt0 && mis0;
      bus.m1_rvalid <= gnt1;
      bus.m1_rdata  <= (gnt1 && !bus.m1_we && !mis1) ? bus.mem_rd_data : '0;
      bus.m1_rerr   <= gnt1 && mis1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model that
// performs RISC-V load extraction and store lane merging.
module tb_dmem_arbiter;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] starve_cnt;
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [31:0] exp_q[$];

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .starve_cnt (starve_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: 16 words
  logic [31:0] mem [0:15] = '{default: 32'h0};
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_word = mem[bus.mem_addr[5:2]];
    rd_byte = rd_word[8*bus.mem_addr[1:0] +: 8];
    rd_half = rd_word[16*bus.mem_addr[1] +: 16];
    case (bus.mem_funct3)
      LB:      bus.mem_rd_data = {{24{rd_byte[7]}}, rd_byte};
      LH:      bus.mem_rd_data = {{16{rd_half[15]}}, rd_half};
      LBU:     bus.mem_rd_data = {24'h0, rd_byte};
      LHU:     bus.mem_rd_data = {16'h0, rd_half};
      default: bus.mem_rd_data = rd_word;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      case (bus.mem_funct3[1:0])
        2'b00:   mem[bus.mem_addr[5:2]][8*bus.mem_addr[1:0] +: 8]  <= bus.mem_wr_data[7:0];
        2'b01:   mem[bus.mem_addr[5:2]][16*bus.mem_addr[1] +: 16] <= bus.mem_wr_data[15:0];
        default: mem[bus.mem_addr[5:2]] <= bus.mem_wr_data;
      endcase
    end
  end

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_funct3 = f3;
      bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_funct3 = f3;
      bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  // Issue one access on a port alone and advance to its response cycle.
  task automatic issue(input int port, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata);
    idle();
    drive(port, 1'b1, we, f3, addr, wdata);
    exp_q.push_back(exp_rdata);
    #1;
    check($sformatf("gnt_p%0d", port), port == 0 ? bus.m0_gnt : bus.m1_gnt, 1);
    check("gnt_other", port == 0 ? bus.m1_gnt : bus.m0_gnt, 0);
    cycle();
    idle();
  endtask

  task automatic resp_check(input int port, input logic exp_rerr);
    logic [31:0] exp_d;
    exp_d = exp_q.pop_front();
    check($sformatf("rvalid_p%0d", port), port == 0 ? bus.m0_rvalid : bus.m1_rvalid, 1);
    check("rvalid_other", port == 0 ? bus.m1_rvalid : bus.m0_rvalid, 0);
    check($sformatf("rdata_p%0d", port), port == 0 ? bus.m0_rdata : bus.m1_rdata, exp_d);
    check($sformatf("rerr_p%0d", port), port == 0 ? bus.m0_rerr : bus.m1_rerr, {31'h0, exp_rerr});
  endtask

  initial begin
    logic exp_mis;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    idle();
    reset = 1'b1;

    // reset held two cycles with a store request from m0
    drive(0, 1'b1, 1'b1, SW, 32'h0, 32'h5555_5555);
    #1;
    check("rst_gnt_visible", bus.m0_gnt, 1);
    check("rst_no_wr_en", bus.mem_wr_en, 0);
    cycle();
    check("rst_rvalid0", bus.m0_rvalid, 0);
    #1;
    check("rst_no_wr_en2", bus.mem_wr_en, 0);
    cycle();
    reset = 1'b0;
    idle();
    #1;
    check("rst_rvalid0_after", bus.m0_rvalid, 0);
    check("rst_rvalid1_after", bus.m1_rvalid, 0);
    check("rst_rerr0", bus.m0_rerr, 0);
    check("rst_starve", {28'h0, starve_cnt}, 0);
    check("rst_mem_word0", mem[0], 0);
    check("idle_mem_addr", bus.mem_addr, 0);
    check("idle_mem_wr_en", bus.mem_wr_en, 0);
    cycle();

    // sw then lw to the same word, back to back
    drive(0, 1'b1, 1'b1, SW, 32'h8, 32'hDEAD_BEEF);
    exp_q.push_back(32'h0);
    #1;
    check("sw_gnt0", bus.m0_gnt, 1);
    check("sw_wr_en", bus.mem_wr_en, 1);
    check("sw_addr", bus.mem_addr, 32'h8);
    check("sw_wdata", bus.mem_wr_data, 32'hDEAD_BEEF);
    cycle();
    resp_check(0, 1'b0);
    drive(0, 1'b1, 1'b0, LW, 32'h8, 32'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    check("lw_gnt0", bus.m0_gnt, 1);
    cycle();
    idle();
    resp_check(0, 1'b0);
    cycle();
    check("after_resp_rvalid0", bus.m0_rvalid, 0);

    // both requesting continuously: m0 x4, then m1, repeating
    drive(0, 1'b1, 1'b0, LW, 32'h8, 32'h0);
    drive(1, 1'b1, 1'b0, LW, 32'hC, 32'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("starve_gnt0_%0d", i), bus.m0_gnt, (i % 5) != 4);
      check($sformatf("starve_gnt1_%0d", i), bus.m1_gnt, (i % 5) == 4);
      check($sformatf("starve_cnt_%0d", i), {28'h0, starve_cnt}, i % 5);
      cycle();
      check($sformatf("starve_rv1_%0d", i), bus.m1_rvalid, (i % 5) == 4);
      check($sformatf("starve_rv0_%0d", i), bus.m0_rvalid, (i % 5) != 4);
    end
    idle();
    cycle();
    check("starve_cleared", {28'h0, starve_cnt}, 0);

    // sign / zero extended byte loads by m1
    issue(1, 1'b1, SW, 32'h0, 32'h8011_2233, 32'h0);
    resp_check(1, 1'b0);
    issue(1, 1'b0, LB, 32'h3, 32'h0, 32'hFFFF_FF80);
    resp_check(1, 1'b0);
    issue(1, 1'b0, LBU, 32'h3, 32'h0, 32'h0000_0080);
    resp_check(1, 1'b0);
    issue(1, 1'b0, LHU, 32'h2, 32'h0, 32'h0000_8011);
    resp_check(1, 1'b0);

    // misaligned store from m1
    issue(1, 1'b1, SW, 32'h4, 32'h1234_5678, 32'h0);
    resp_check(1, 1'b0);
    idle();
    drive(1, 1'b1, 1'b1, SW, 32'h6, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    #1;
    check("mis_gnt1", bus.m1_gnt, 1);
    check("mis_wr_en", bus.mem_wr_en, {31'h0, !exp_mis});
    cycle();
    idle();
    resp_check(1, exp_mis);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
    issue(1, 1'b0, LW, 32'h4, 32'h0, 32'h1234_5678);
    resp_check(1, 1'b0);
    issue(1, 1'b0, LH, 32'h5, 32'h0, 32'h0);
    resp_check(1, 1'b1);
`endif

    // halfword store merge
    issue(0, 1'b1, SW, 32'h0, 32'hAAAA_BBBB, 32'h0);
    resp_check(0, 1'b0);
    issue(0, 1'b1, SH, 32'h2, 32'h0000_1234, 32'h0);
    resp_check(0, 1'b0);
    issue(0, 1'b0, LW, 32'h0, 32'h0, 32'h1234_BBBB);
    resp_check(0, 1'b0);
    issue(0, 1'b0, LH, 32'h2, 32'h0, 32'h0000_1234);
    resp_check(0, 1'b0);

    // reset during a granted store: no write, response dropped
    drive(0, 1'b1, 1'b1, SW, 32'h0, 32'h0BAD_0BAD);
    reset = 1'b1;
    #1;
    check("midrst_wr_en", bus.mem_wr_en, 0);
    cycle();
    reset = 1'b0;
    idle();
    check("midrst_rvalid0", bus.m0_rvalid, 0);
    check("midrst_mem", mem[0], 32'h1234_BBBB);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    n_checks++;
    n_fails++;
    $display("FAIL timeout: got no end of test, expected finish before 100000");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
